mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: the CPU always wins, the loader/DMA port uses idle CPU cycles.
// Optional saturating performance counters are built when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_op,
    input  logic [31:0] cpu_MAR,
    input  logic [31:0] cpu_MBR_out,
    output logic [31:0] cpu_MBR_in,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [15:0] perf_cpu_acc,
    output logic [15:0] perf_dma_acc,
    output logic [15:0] perf_dma_wait
`endif
);

    typedef enum logic [2:0] {
        OWN_IDLE   = 3'd0,
        OWN_CPU_RD = 3'd1,
        OWN_CPU_WR = 3'd2,
        OWN_DMA_RD = 3'd3,
        OWN_DMA_WR = 3'd4
    } owner_t;

    owner_t      owner;
    owner_t      owner_next;
    logic [31:0] cpu_hold;
    logic [31:0] dma_hold;
    logic        cpu_rd_return;
    logic        dma_rd_return;

    always_ff @(posedge clock) begin
        if (reset) begin
            owner <= OWN_IDLE;
        end else begin
            owner <= owner_next;
        end
    end

    // A read issued last cycle returns now; reset discards it so nothing in flight survives.
    assign cpu_rd_return = (owner == OWN_CPU_RD) && !reset;
    assign dma_rd_return = (owner == OWN_DMA_RD) && !reset;

    always_comb begin
        owner_next = OWN_IDLE;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        dma_gnt    = 1'b0;
        if (!reset) begin
            if (cpu_mem_enable) begin
                mem_en     = 1'b1;
                mem_we     = cpu_mem_op;
                mem_addr   = cpu_MAR;
                mem_wdata  = cpu_MBR_out;
                owner_next = cpu_mem_op ? OWN_CPU_WR : OWN_CPU_RD;
            end else if (dma_req) begin
                mem_en     = 1'b1;
                mem_we     = dma_we;
                mem_addr   = dma_addr;
                mem_wdata  = dma_wdata;
                dma_gnt    = 1'b1;
                owner_next = dma_we ? OWN_DMA_WR : OWN_DMA_RD;
            end
        end

        cpu_MBR_in = cpu_hold;
        dma_rdata  = dma_hold;
        dma_rvalid = dma_rd_return;
        if (reset) begin
            cpu_MBR_in = 32'd0;
            dma_rdata  = 32'd0;
        end else begin
            if (cpu_rd_return) begin
                cpu_MBR_in = mem_rdata;
            end
            if (dma_rd_return) begin
                dma_rdata = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_hold <= 32'd0;
            dma_hold <= 32'd0;
        end else begin
            if (cpu_rd_return) begin
                cpu_hold <= mem_rdata;
            end
            if (dma_rd_return) begin
                dma_hold <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    logic cpu_acc_event;
    logic dma_wait_event;

    assign cpu_acc_event  = cpu_mem_enable && !reset;
    assign dma_wait_event = dma_req && !dma_gnt && !reset;

    // Counters stick at all-ones rather than wrapping so long runs stay meaningful.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cpu_acc  <= 16'd0;
            perf_dma_acc  <= 16'd0;
            perf_dma_wait <= 16'd0;
        end else begin
            if (cpu_acc_event && (perf_cpu_acc != 16'hFFFF)) begin
                perf_cpu_acc <= perf_cpu_acc + 16'd1;
            end
            if (dma_gnt && (perf_dma_acc != 16'hFFFF)) begin
                perf_dma_acc <= perf_dma_acc + 16'd1;
            end
            if (dma_wait_event && (perf_dma_wait != 16'hFFFF)) begin
                perf_dma_wait <= perf_dma_wait + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized CPU/DMA traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_mem_enable;
    logic        cpu_mem_op;
    logic [31:0] cpu_MAR;
    logic [31:0] cpu_MBR_out;
    logic [31:0] cpu_MBR_in;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_ARBITER_PERF_EN
    logic [15:0] perf_cpu_acc;
    logic [15:0] perf_dma_acc;
    logic [15:0] perf_dma_wait;
`endif

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_mem_enable (cpu_mem_enable),
        .cpu_mem_op     (cpu_mem_op),
        .cpu_MAR        (cpu_MAR),
        .cpu_MBR_out    (cpu_MBR_out),
        .cpu_MBR_in     (cpu_MBR_in),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_gnt        (dma_gnt),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .perf_cpu_acc   (perf_cpu_acc),
        .perf_dma_acc   (perf_dma_acc),
        .perf_dma_wait  (perf_dma_wait)
`endif
    );

    // Synchronous single-port memory attached to the arbiter (16 words, low address bits).
    logic [31:0] mem_array [16];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr[3:0]];
        end
    end

    typedef struct packed {
        logic        gnt;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] cpu_data;
        logic        rvalid;
        logic [31:0] dma_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] dma_resp_q[$];
    exp_t        mon_e;

    int total = 0;
    int bad   = 0;

    // Reference model state: memory image plus what each requester should currently see.
    logic [31:0] ref_mem [16];
    logic [31:0] ref_cpu_hold;
    logic [31:0] ref_dma_hold;
    logic        ref_cpu_pending;
    logic [31:0] ref_cpu_val;
    logic        ref_dma_pending;
    logic [31:0] ref_dma_val;
    logic        last_gnt;

    logic        r_ce;
    logic        r_op;
    logic        r_rst;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_dq;
    logic        r_dw;
    logic [31:0] r_da;
    logic [31:0] r_dd;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelCycle();
        exp_t e;
        e = '0;
        last_gnt = 1'b0;
        if (reset) begin
            ref_cpu_hold    = 32'd0;
            ref_dma_hold    = 32'd0;
            ref_cpu_pending = 1'b0;
            ref_dma_pending = 1'b0;
            dma_resp_q.delete();
        end else begin
            if (ref_cpu_pending) ref_cpu_hold = ref_cpu_val;
            if (ref_dma_pending) ref_dma_hold = ref_dma_val;
            e.rvalid        = ref_dma_pending;
            e.cpu_data      = ref_cpu_hold;
            e.dma_data      = ref_dma_hold;
            ref_cpu_pending = 1'b0;
            ref_dma_pending = 1'b0;
            if (cpu_mem_enable) begin
                e.en    = 1'b1;
                e.we    = cpu_mem_op;
                e.addr  = cpu_MAR;
                e.wdata = cpu_MBR_out;
                if (cpu_mem_op) begin
                    ref_mem[cpu_MAR[3:0]] = cpu_MBR_out;
                end else begin
                    ref_cpu_pending = 1'b1;
                    ref_cpu_val     = ref_mem[cpu_MAR[3:0]];
                end
            end else if (dma_req) begin
                e.en     = 1'b1;
                e.gnt    = 1'b1;
                e.we     = dma_we;
                e.addr   = dma_addr;
                e.wdata  = dma_wdata;
                last_gnt = 1'b1;
                if (dma_we) begin
                    ref_mem[dma_addr[3:0]] = dma_wdata;
                end else begin
                    ref_dma_pending = 1'b1;
                    ref_dma_val     = ref_mem[dma_addr[3:0]];
                    dma_resp_q.push_back(ref_dma_val);
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input logic ce, input logic op,
                                 input logic [31:0] ma, input logic [31:0] md,
                                 input logic dq, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd);
        @(posedge clock);
        #1;
        reset          = rst;
        cpu_mem_enable = ce;
        cpu_mem_op     = op;
        cpu_MAR        = ma;
        cpu_MBR_out    = md;
        dma_req        = dq;
        dma_we         = dw;
        dma_addr       = da;
        dma_wdata      = dd;
        modelCycle();
    endtask

    // Monitor: one expected record per cycle, plus DMA responses popped on dma_rvalid.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("dma_gnt",    32'(dma_gnt),    32'(mon_e.gnt));
            checkOutput("mem_en",     32'(mem_en),     32'(mon_e.en));
            checkOutput("mem_we",     32'(mem_we),     32'(mon_e.we));
            checkOutput("mem_addr",   mem_addr,        mon_e.addr);
            checkOutput("mem_wdata",  mem_wdata,       mon_e.wdata);
            checkOutput("cpu_MBR_in", cpu_MBR_in,      mon_e.cpu_data);
            checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(mon_e.rvalid));
            checkOutput("dma_rdata",  dma_rdata,       mon_e.dma_data);
        end
        if (dma_rvalid === 1'b1) begin
            if (dma_resp_q.size() == 0) begin
                checkOutput("dma_resp_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("dma_resp_data", dma_rdata, dma_resp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_array[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        end
        mem_array[5] = 32'hDEADBEEF;
        mem_array[9] = 32'hCAFE0009;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_array[i];
        ref_cpu_hold    = 32'd0;
        ref_dma_hold    = 32'd0;
        ref_cpu_pending = 1'b0;
        ref_dma_pending = 1'b0;
        ref_cpu_val     = 32'd0;
        ref_dma_val     = 32'd0;
        last_gnt        = 1'b0;
        reset          = 1'b1;
        cpu_mem_enable = 1'b0;
        cpu_mem_op     = 1'b0;
        cpu_MAR        = 32'd0;
        cpu_MBR_out    = 32'd0;
        dma_req        = 1'b0;
        dma_we         = 1'b0;
        dma_addr       = 32'd0;
        dma_wdata      = 32'd0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] CPU read of word 5");
        applyStimulus(0, 1, 0, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] collision: CPU read vs DMA read of word 9");
        applyStimulus(0, 1, 0, 7, 0, 1, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] DMA write of word 3 then CPU read back");
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 3, 32'h12345678);
        applyStimulus(0, 1, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] DMA streaming reads of words 0,1,2");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset while a DMA read is in flight");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 4, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] withdrawn DMA request");
        applyStimulus(0, 1, 1, 6, 32'hA5A5A5A5, 1, 0, 8, 0);
        applyStimulus(0, 1, 0, 6, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        r_dq = 1'b0;
        r_dw = 1'b0;
        r_da = 32'd0;
        r_dd = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (last_gnt) r_dq = 1'b0;
            if (r_dq && ($urandom_range(0, 9) == 0)) r_dq = 1'b0;
            if (!r_dq && ($urandom_range(0, 2) != 0)) begin
                r_dq = 1'b1;
                r_dw = ($urandom_range(0, 1) == 1);
                r_da = $urandom_range(0, 15);
                r_dd = $urandom;
            end
            r_rst  = ($urandom_range(0, 49) == 0);
            r_ce   = ($urandom_range(0, 1) == 1);
            r_op   = ($urandom_range(0, 1) == 1);
            r_addr = $urandom_range(0, 15);
            r_data = $urandom;
            applyStimulus(r_rst, r_ce, r_op, r_addr, r_data, r_dq, r_dw, r_da, r_dd);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef MEM_ARBITER_PERF_EN
        $display("[TB] performance counters");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        checkOutput("perf_wait_reset", 32'(perf_dma_wait), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 2, 32'(i), 1, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        checkOutput("perf_dma_wait", 32'(perf_dma_wait), 32'd4);
        checkOutput("perf_cpu_acc",  32'(perf_cpu_acc),  32'd4);
        checkOutput("perf_dma_acc",  32'(perf_dma_acc),  32'd0);
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(0, 1, 1, 2, 32'(i), 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        checkOutput("perf_cpu_sat", 32'(perf_cpu_acc), 32'h0000FFFF);
`endif

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        checkOutput("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("dma_resp_drained",  32'(dma_resp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
